// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one external combinational ALU between two
// valid/ready requesters; operands are registered to the ALU, results captured a cycle later.
module alu_share_ctrl #(
    parameter int WIDTH = 4,
    parameter int OPW   = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_overflow,
    output logic             resp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             busy,
    output logic [CNTW-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [OPW-1:0]    alu_op_q, alu_op_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [CNTW-1:0]   ops_q, ops_d;
    logic              grant_valid_s;
    logic              grant_s;

    // Next-state, grant selection and datapath register updates
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        res_d         = res_q;
        ovf_d         = ovf_q;
        zero_d        = zero_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        ops_d         = ops_q;
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time is served.
                if (req0_valid && req1_valid) begin
                    grant_valid_s = 1'b1;
                    grant_s       = ~last_grant_q;
                end else if (req0_valid) begin
                    grant_valid_s = 1'b1;
                    grant_s       = 1'b0;
                end else if (req1_valid) begin
                    grant_valid_s = 1'b1;
                    grant_s       = 1'b1;
                end else begin
                    grant_valid_s = 1'b0;
                    grant_s       = 1'b0;
                end
                if (grant_valid_s) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    state_d      = EXEC;
                    if (grant_s) begin
                        alu_a_d  = req1_a;
                        alu_b_d  = req1_b;
                        alu_op_d = req1_op;
                    end else begin
                        alu_a_d  = req0_a;
                        alu_b_d  = req0_b;
                        alu_op_d = req0_op;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                res_d         = alu_result;
                ovf_d         = alu_overflow;
                zero_d        = alu_zero;
                resp0_valid_d = ~owner_q;
                resp1_valid_d = owner_q;
                state_d       = RESP;
            end
            RESP: begin
                if ((resp0_valid_q && resp0_ready) || (resp1_valid_q && resp1_ready)) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    state_d       = IDLE;
                    if (ops_q != {CNTW{1'b1}}) begin
                        ops_d = ops_q + {{(CNTW-1){1'b0}}, 1'b1};
                    end else begin
                        ops_d = ops_q;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d       = IDLE;
                resp0_valid_d = 1'b0;
                resp1_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            alu_a_q       <= {WIDTH{1'b0}};
            alu_b_q       <= {WIDTH{1'b0}};
            alu_op_q      <= {OPW{1'b0}};
            res_q         <= {WIDTH{1'b0}};
            ovf_q         <= 1'b0;
            zero_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            ops_q         <= {CNTW{1'b0}};
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            res_q         <= res_d;
            ovf_q         <= ovf_d;
            zero_q        <= zero_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            ops_q         <= ops_d;
        end
    end

    // Ready is a combinational decode of the IDLE-state grant.
    assign req0_ready    = grant_valid_s & ~grant_s;
    assign req1_ready    = grant_valid_s & grant_s;
    assign resp0_valid   = resp0_valid_q;
    assign resp1_valid   = resp1_valid_q;
    assign resp_result   = res_q;
    assign resp_overflow = ovf_q;
    assign resp_zero     = zero_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign busy          = (state_q != IDLE);
    assign ops_done      = ops_q;

endmodule
